// File: rtl/fft_bin_power_pkg.sv
// fft_bin_power_pkg: Q10.5 constants, FSM states and saturating add shared by the
// FFT power stages.
package fft_bin_power_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 5;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {IDLE, SQ_RE, WAIT_RE, SQ_IM, WAIT_IM, EMIT} state_t;

    // Signed add with one guard bit; an overflow clamps toward the sign of the true sum.
    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] s;
        s = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
        return (s[DATA_WIDTH] != s[DATA_WIDTH-1]) ? (s[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
                                                  : s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// fixed_point_multiplier: two-stage signed fixed-point multiply, re-scaled to P_EXP
// fractional bits with truncation toward zero and saturation to WIDTH bits.
module fixed_point_multiplier #(
    parameter int WIDTH = 16,
    parameter int A_EXP = 5,
    parameter int B_EXP = 5,
    parameter int P_EXP = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int PW = 2 * WIDTH;
    localparam int SH = A_EXP + B_EXP - P_EXP;
    localparam logic signed [PW-1:0] BIAS = PW'((1 << SH) - 1);
    localparam logic signed [PW-1:0] QMAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] QMIN = ~QMAX;

    logic signed [PW-1:0] prod_r;
    logic signed [PW-1:0] q;
    logic                 v_r;

    // Negative products get a bias before the shift so the drop of low bits rounds toward zero.
    assign q = (prod_r[PW-1] ? prod_r + BIAS : prod_r) >>> SH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0;
            v_r    <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            if (en) prod_r <= PW'($signed(a)) * PW'($signed(b));
            v_r  <= en;
            done <= v_r;
            if (v_r) p <= q > QMAX ? QMAX[WIDTH-1:0] : q < QMIN ? QMIN[WIDTH-1:0] : q[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fft_bin_power.sv
// fft_bin_power: per-bin power re^2 + im^2 in Q10.5 through one shared multiplier,
// plus per-frame strongest-bin tracking reported at frame end.
module fft_bin_power
    import fft_bin_power_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 5,
    parameter int INDEX_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_re,
    input  logic [DATA_WIDTH-1:0]  in_im,
    input  logic                   in_last,
    output logic                   pow_valid,
    output logic [DATA_WIDTH-1:0]  pow,
    output logic [INDEX_WIDTH-1:0] pow_index,
    output logic                   peak_valid,
    output logic [INDEX_WIDTH-1:0] peak_index,
    output logic [DATA_WIDTH-1:0]  peak_power
);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  re_r, im_r, sq_re, sq_im, run_pow;
    logic [DATA_WIDTH-1:0]  mul_a, mul_p, sq, pw;
    logic [INDEX_WIDTH-1:0] cnt, run_idx;
    logic                   last_r, mul_en, mul_done, take;

    assign mul_en = (state == SQ_RE) || (state == SQ_IM);
    assign mul_a  = (state == SQ_RE) ? re_r : im_r;
    // A square can never be negative, so a set sign bit can only mean overflow.
    assign sq     = mul_p[DATA_WIDTH-1] ? SAT_MAX : mul_p;
    assign pw     = sat_add(sq_re, sq_im);
    assign take   = (cnt == '0) || (pw > run_pow);

    fixed_point_multiplier #(
        .WIDTH (DATA_WIDTH),
        .A_EXP (FRAC_BITS),
        .B_EXP (FRAC_BITS),
        .P_EXP (FRAC_BITS)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mul_en),
        .a     (mul_a),
        .b     (mul_a),
        .p     (mul_p),
        .done  (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            pow_valid  <= 1'b0;
            pow        <= '0;
            pow_index  <= '0;
            peak_valid <= 1'b0;
            peak_index <= '0;
            peak_power <= '0;
            re_r       <= '0;
            im_r       <= '0;
            last_r     <= 1'b0;
            sq_re      <= '0;
            sq_im      <= '0;
            cnt        <= '0;
            run_idx    <= '0;
            run_pow    <= '0;
        end else begin
            pow_valid  <= 1'b0;
            peak_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    re_r     <= in_re;
                    im_r     <= in_im;
                    last_r   <= in_last;
                    in_ready <= 1'b0;
                    state    <= SQ_RE;
                end
                SQ_RE: state <= WAIT_RE;
                WAIT_RE: if (mul_done) begin
                    sq_re <= sq;
                    state <= SQ_IM;
                end
                SQ_IM: state <= WAIT_IM;
                WAIT_IM: if (mul_done) begin
                    sq_im <= sq;
                    state <= EMIT;
                end
                EMIT: begin
                    pow       <= pw;
                    pow_valid <= 1'b1;
                    pow_index <= cnt;
                    if (take) begin
                        run_idx <= cnt;
                        run_pow <= pw;
                    end
                    // A counter wrap without last simply starts a new frame at index 0.
                    if (last_r) begin
                        peak_valid <= 1'b1;
                        peak_index <= take ? cnt : run_idx;
                        peak_power <= take ? pw : run_pow;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_power.sv
// tb_fft_bin_power: table vectors, hand sequences and randomized bins checked
// against an arithmetic power/peak model.
module tb_fft_bin_power;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0, in_im = '0;
    logic        in_last = 1'b0;
    logic        pow_valid, peak_valid;
    logic [15:0] pow, peak_power;
    logic [8:0]  pow_index, peak_index;

    typedef struct {logic [15:0] re; logic [15:0] im; logic last; logic [15:0] pw;} vec_t;
    typedef struct {logic [15:0] pw; logic [8:0] idx; logic pv; logic [8:0] pidx; logic [15:0] ppw; int cyc;} res_t;
    typedef struct {logic [15:0] re; logic [15:0] im; logic last; int cyc;} acc_t;

    res_t resq[$];
    acc_t accq[$];
    int   cyc = 0, pulses = 0, exp_pulses = 0;
    int   checks = 0, errors = 0;

    fft_bin_power dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .pow_valid  (pow_valid),
        .pow        (pow),
        .pow_index  (pow_index),
        .peak_valid (peak_valid),
        .peak_index (peak_index),
        .peak_power (peak_power)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) accq.push_back('{in_re, in_im, in_last, cyc + 1});
        if (pow_valid) begin
            pulses++;
            resq.push_back('{pow, pow_index, peak_valid, peak_index, peak_power, cyc});
        end
        if (peak_valid) begin
            checks++;
            if (!pow_valid) begin
                errors++;
                $display("FAIL peak_without_pow: peak_valid=1 pow_valid=%0d required 1", pow_valid);
            end
        end
    end

    function automatic int sqm(logic [15:0] x);
        longint v, p;
        v = longint'($signed(x));
        p = (v * v) >>> 5;
        return p > 32767 ? 32767 : int'(p);
    endfunction

    function automatic int powm(logic [15:0] re, logic [15:0] im);
        int s;
        s = sqm(re) + sqm(im);
        return s > 32767 ? 32767 : s;
    endfunction

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        in_last = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get(input string n, output res_t r, output acc_t a);
        for (int i = 0; i < 30 && resq.size() == 0; i++) @(negedge clk);
        r = '{16'h0, 9'h0, 1'b0, 9'h0, 16'h0, 0};
        a = '{16'h0, 16'h0, 1'b0, 0};
        if (resq.size() == 0) begin
            chk({n, "_result_timeout"}, 0, 1);
            return;
        end
        r = resq.pop_front();
        exp_pulses++;
        if (accq.size() == 0) begin
            chk({n, "_no_accept"}, 0, 1);
            return;
        end
        a = accq.pop_front();
        chk({n, "_latency"}, r.cyc - a.cyc, LAT);
    endtask

    initial begin
        vec_t  tbl[6];
        res_t  r;
        acc_t  a, acc[3];
        int    fq[$];
        int    pexp[4];
        int    p0, bi;
        logic  lst;
        logic [15:0] re, im;

        tbl[0] = '{16'h0060, 16'h0080, 1'b1, 16'h0320};
        tbl[1] = '{16'hFC40, 16'h0000, 1'b1, 16'h7080};
        tbl[2] = '{16'h0001, 16'h0001, 1'b1, 16'h0000};
        tbl[3] = '{16'h03C0, 16'h03C0, 1'b1, 16'h7FFF};
        tbl[4] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF};
        tbl[5] = '{16'h0020, 16'h0020, 1'b1, 16'h0040};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pow_valid", pow_valid, 0);
        chk("rst_pow", pow, 0);
        chk("rst_pow_index", pow_index, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_index", peak_index, 0);
        chk("rst_peak_power", peak_power, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            send(tbl[i].re, tbl[i].im, tbl[i].last);
            get("tbl", r, a);
            chk($sformatf("tbl%0d_pow", i), r.pw, tbl[i].pw);
            chk($sformatf("tbl%0d_idx", i), r.idx, 0);
            chk($sformatf("tbl%0d_pv", i), r.pv, 1);
            chk($sformatf("tbl%0d_pidx", i), r.pidx, 0);
            chk($sformatf("tbl%0d_ppw", i), r.ppw, tbl[i].pw);
            repeat (3) @(negedge clk);
            chk($sformatf("tbl%0d_single_pulse", i), pulses, exp_pulses);
        end

        pexp = '{16'h0020, 16'h0120, 16'h0120, 16'h0080};
        for (int i = 0; i < 4; i++) begin
            re = (i == 0) ? 16'h0020 : (i == 3) ? 16'h0040 : 16'h0060;
            send(re, 16'h0000, i == 3);
            get("frame", r, a);
            chk($sformatf("frame%0d_pow", i), r.pw, pexp[i]);
            chk($sformatf("frame%0d_idx", i), r.idx, i);
            chk($sformatf("frame%0d_pv", i), r.pv, i == 3);
        end
        chk("frame_peak_index", r.pidx, 1);
        chk("frame_peak_power", r.ppw, 16'h0120);
        repeat (2) @(negedge clk);
        chk("frame_peak_index_held", peak_index, 1);
        send(16'h0040, 16'h0000, 1'b1);
        get("next_frame", r, a);
        chk("next_frame_idx", r.idx, 0);
        chk("next_frame_pow", r.pw, 16'h0080);

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_re = 16'($urandom_range(0, 16'h0600));
        in_im = 16'($urandom_range(0, 16'h0600));
        for (int i = 0; i < 60 && accq.size() < 3; i++) begin
            @(posedge clk);
            #1;
            in_re = 16'($urandom_range(0, 16'h0600)) - 16'h0300;
            in_im = 16'($urandom_range(0, 16'h0600)) - 16'h0300;
        end
        in_valid = 1'b0;
        chk("bp_accepts", accq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            get("bp", r, acc[k]);
            chk($sformatf("bp%0d_pow", k), r.pw, powm(acc[k].re, acc[k].im));
        end
        chk("bp_gap01", acc[1].cyc - acc[0].cyc, LAT + 1);
        chk("bp_gap12", acc[2].cyc - acc[1].cyc, LAT + 1);
        repeat (12) @(negedge clk);
        chk("bp_no_extra_accept", accq.size(), 0);

        send(16'h03C0, 16'h0100, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        chk("midrst_pow_valid", pow_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_pow", pow, 0);
        chk("midrst_pow_index", pow_index, 0);
        chk("midrst_peak_power", peak_power, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_pulse", pulses, p0);
        accq.delete();
        resq.delete();
        send(16'h0020, 16'h0020, 1'b1);
        get("postrst", r, a);
        chk("postrst_pow", r.pw, 16'h0040);
        chk("postrst_idx", r.idx, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                re = 16'($urandom);
                im = 16'($urandom);
            end else begin
                re = 16'($urandom_range(0, 16'h0A00)) - 16'h0500;
                im = 16'($urandom_range(0, 16'h0A00)) - 16'h0500;
            end
            lst = ($urandom_range(0, 4) == 0) || (i == 39);
            send(re, im, lst);
            get("rnd", r, a);
            chk($sformatf("rnd%0d_pow", i), r.pw, powm(re, im));
            chk($sformatf("rnd%0d_idx", i), r.idx, fq.size());
            chk($sformatf("rnd%0d_pv", i), r.pv, lst);
            fq.push_back(powm(re, im));
            if (lst) begin
                bi = 0;
                foreach (fq[k]) if (fq[k] > fq[bi]) bi = k;
                chk($sformatf("rnd%0d_pidx", i), r.pidx, bi);
                chk($sformatf("rnd%0d_ppw", i), r.ppw, fq[bi]);
                fq.delete();
            end
        end

        repeat (5) @(negedge clk);
        chk("total_pulses", pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
